id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the EX-stage ALU.
- Registers decoded operands and control from ID, and resolves RAW forwarding from EX/MEM and MEM/WB.
- Applies the ALU-source immediate mux and drives op1/op2/ALU_control straight into the ALU.
- Detects load-use hazards and inserts one bubble; supports stall (hold) and flush (bubble).

Parameters:
- WIDTH, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  downstream freeze; hold all EX state
- flush  in  1  squash; load a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  RA_W  register addresses
- id_alu_control  in  3  ALU op (000 and, 001 or, 010 add, 100 sub, 101 mul, 110 slt)
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded control
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  RA_W  EX/MEM destination
- exmem_result  in  WIDTH  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  RA_W  MEM/WB destination
- memwb_result  in  WIDTH  MEM/WB write-back value
- alu_op1, alu_op2  out  WIDTH  ALU operands
- alu_control  out  3  registered ALU op
- ex_store_data  out  WIDTH  forwarded rt value for sw
- ex_dest  out  RA_W  id_rd if reg_dst else id_rt, registered
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control, qualified by valid
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID

Behaviour:
- Register update priority per edge:
  - !rst_n: bubble.
  - flush: bubble.
  - stall: hold every register.
  - load_use_stall: bubble.
  - otherwise: load all ID inputs.
- Bubble contents: ex_valid=0, all ex control bits 0, alu_control 000, data/address registers 0.
- Reset values: every output 0, load_use_stall 0.
- Flush asserted together with stall: flush wins.
- Reset mid-stall: clears state.
- Latency: ID inputs appear on the registered outputs one cycle after load.
- load_use_stall is asserted when all of the following hold:
  - ex_valid, ex_mem_read, id_valid;
  - ex_dest != 0;
  - ex_dest == id_rs, or (ex_dest == id_rt and the instruction uses rt). rt is used when !id_alu_src or id_mem_write.
- A load-use stall inserts exactly one bubble. The next cycle re-evaluates with the load now in MEM, so the stall deasserts.
- Forwarding select per source operand (registered rs/rt):
  - EX/MEM when exmem_reg_write, exmem_rd != 0 and exmem_rd matches.
  - Else MEM/WB when memwb_reg_write, memwb_rd != 0 and memwb_rd matches.
  - Else the registered register-file data.
  - EX/MEM always has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand outputs:
  - alu_op1 = forwarded rs.
  - alu_op2 = registered imm if alu_src, else forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src.
- All outputs are combinational from registers plus forwarding inputs. There is no extra latency on the forwarding path.
- During stall, forwarding keeps tracking the live exmem/memwb inputs. The held instruction consumes the values present on the cycle stall deasserts.
- ex_* control bits are forced 0 whenever ex_valid=0.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - No forwarding; operands come only from registered register-file data.
  - exmem_* and memwb_* inputs are ignored.
  - load_use_stall also asserts for any valid EX or EX/MEM register-writing instruction whose destination matches a used source (full interlock). Non-zero destinations only.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id inputs active -> all outputs 0. Release, load add rs=5 (data 7), rt=6 (data 3) -> next cycle alu_op1=7, alu_op2=3, alu_control=010, ex_valid=1.
- Forward priority: EX holds rs=8; exmem_rd=8 result 0x11; memwb_rd=8 result 0x22 -> alu_op1=0x11. Drop exmem_reg_write -> alu_op1=0x22. Set rd=0 on both -> register-file value.
- Load-use: lw $9 in EX (mem_read=1, dest=9), ID add uses rs=9 -> load_use_stall=1. Next cycle ex_valid=0 and load_use_stall=0. Same instruction loads the following cycle.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen. stall=1 with flush=1 -> bubble (ex_valid=0, ex_reg_write=0).
- Immediate/store: sw with alu_src=1, imm=0x10, rt forwarded from memwb 0xABCD -> alu_op2=0x10, ex_store_data=0xABCD, ex_mem_write=1.
- Macro undefined: exmem_rd=8 with write, ID uses rs=8 -> load_use_stall=1, and alu_op1 ignores exmem_result.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU-source mux and load-use hazard detection.
// Define ID_EX_FORWARD_EN to get the forwarding muxes; without it the stage forwards nothing and fully interlocks instead.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [2:0]       id_alu_control,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA_W-1:0]  ex_dest,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             load_use_stall
);

  logic             valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q;
  logic [2:0]       alu_ctl_q;
  logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic [RA_W-1:0]  rs_q, rt_q, dest_q;

  logic             rt_used;
  logic             ex_match;
  logic             load_hazard;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  // rt is only a true source when the ALU reads it or a store writes it out
  assign rt_used     = !id_alu_src || id_mem_write;
  assign ex_match    = (dest_q != '0) &&
                       ((dest_q == id_rs) || ((dest_q == id_rt) && rt_used));
  assign load_hazard = id_valid && valid_q && mem_read_q && ex_match;

`ifdef ID_EX_FORWARD_EN
  assign load_use_stall = load_hazard;

  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end
`else
  logic mem_match;
  logic unused_fwd;

  // Without bypass paths any in-flight producer in EX or EX/MEM must drain first
  assign mem_match = (exmem_rd != '0) &&
                     ((exmem_rd == id_rs) || ((exmem_rd == id_rt) && rt_used));
  assign load_use_stall = load_hazard ||
                          (id_valid && ((valid_q && reg_write_q && ex_match) ||
                                        (exmem_reg_write && mem_match)));
  assign fwd_rs     = rs_data_q;
  assign fwd_rt     = rt_data_q;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, rs_q, rt_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || flush || (!stall && load_use_stall)) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctl_q    <= 3'b000;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      reg_write_q  <= id_reg_write;
      mem_read_q   <= id_mem_read;
      mem_write_q  <= id_mem_write;
      mem_to_reg_q <= id_mem_to_reg;
      alu_src_q    <= id_alu_src;
      alu_ctl_q    <= id_alu_control;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      dest_q       <= id_reg_dst ? id_rd : id_rt;
    end
  end

  assign alu_op1       = fwd_rs;
  assign alu_op2       = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_control   = alu_ctl_q;
  assign ex_dest       = dest_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_mem_to_reg = valid_q & mem_to_reg_q;

endmodule
